ring_counter_param: RTL and testbench

Parametrised shift-register counter: the generalised successor of our fixed 4-bit one-hot ring counter. It runs as a one-hot ring counter or a Johnson (twisted-ring) counter, selectable at run time. It supports up/down direction, clock enable and parallel load, and corrects illegal states to a known legal one. It sits next to the sequencing logic as a decoded phase/slot generator. It also drives a wrap strobe for the downstream slot and frame logic.

---
 rtl/ring_counter_param.sv | 108 ++++++++++
 tb/tb_ring_counter_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_param.sv
// ring_counter_param
// Shift-register phase/slot generator. Runs as a one-hot ring or a Johnson
// (twisted-ring) counter, selected per edge by `mode`. Supports up/down,
// clock enable and parallel load. Any state that is illegal for the current
// mode is replaced by 0...01 on the next enabled edge, flagged by `err`.
// `wrap` marks the cycle after a legal step lands on the mode's home state.

module ring_counter_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             err
);

    // Catch an unsupported width at elaboration instead of building odd logic.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("ring_counter_param: WIDTH must be in 2..32");
    end

    // 0...01 is legal in both modes, so it doubles as reset and recovery state.
    localparam logic [WIDTH-1:0] RESET_STATE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] HOME_RING    = WIDTH'(1);
    localparam logic [WIDTH-1:0] HOME_JOHNSON = '0;
    localparam logic [WIDTH-2:0] DIFF_ONE     = (WIDTH-1)'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             r_err;

    logic [WIDTH-2:0] w_diff;
    logic             w_ring_legal;
    logic             w_john_legal;
    logic             w_legal;
    logic [WIDTH-1:0] w_rot;
    logic [WIDTH-1:0] w_home;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_err_next;

    // Legality of the current state under the currently selected mode.
    // Ring: exactly one bit set (non-zero and a power of two).
    // Johnson: adjacent-bit differences form at most one edge, i.e. the
    // difference vector has zero or one bit set.
    always_comb begin
        w_diff       = r_q[WIDTH-2:0] ^ r_q[WIDTH-1:1];
        w_ring_legal = (r_q != '0) && ((r_q & (r_q - WIDTH'(1))) == '0);
        w_john_legal = ((w_diff & (w_diff - DIFF_ONE)) == '0);
        w_legal      = mode ? w_john_legal : w_ring_legal;
    end

    // Candidate rotated state; Johnson inverts the bit fed back around the ring.
    always_comb begin
        w_rot = r_q;
        case ({mode, dir})
            2'b00:   w_rot = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            2'b01:   w_rot = {r_q[0], r_q[WIDTH-1:1]};
            2'b10:   w_rot = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
            2'b11:   w_rot = {~r_q[0], r_q[WIDTH-1:1]};
            default: w_rot = r_q;
        endcase
        w_home = mode ? HOME_JOHNSON : HOME_RING;
    end

    // Next-state selection: load beats enable, enable beats hold.
    // A correction replaces the step entirely, so it never raises wrap.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        w_err_next  = 1'b0;
        if (load) begin
            w_q_next = load_val;
        end else if (en) begin
            if (!w_legal) begin
                w_q_next   = RESET_STATE;
                w_err_next = 1'b1;
            end else begin
                w_q_next    = w_rot;
                w_wrap_next = (w_rot == w_home);
            end
        end
    end

    // State and strobe registers; strobes self-clear on any non-triggering edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RESET_STATE;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
            r_err  <= w_err_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule

// File: tb/tb_ring_counter_param.sv
// Bench for ring_counter_param. The reference model tracks the counter as a
// position in the mode's legal-state list and advances it with modular
// arithmetic; directed test-plan sequences are followed by random stimulus.

module tb_ring_counter_param;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         dir = 1'b0;
    logic         mode = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         wrap;
    logic         err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_q    = 1;
    logic         m_wrap = 1'b0;
    logic         m_err  = 1'b0;

    ring_counter_param #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .wrap     (wrap),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Legal state number idx of the given mode. Ring: single bit at idx.
    // Johnson: idx ones filling from the LSB, then zeros filling from the LSB.
    function automatic logic [W-1:0] state_of(input logic md, input int idx);
        logic [W-1:0] one;
        logic [W-1:0] mask;
        one  = 1;
        mask = '1;
        if (!md) return one << idx;
        if (idx <= W) return W'((1 << idx) - 1);
        return mask & ~W'((1 << (idx - W)) - 1);
    endfunction

    function automatic int index_of(input logic md, input logic [W-1:0] v);
        int n;
        n = md ? 2 * W : W;
        for (int i = 0; i < n; i++)
            if (state_of(md, i) == v) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic ld, input logic e, input logic d,
                              input logic md, input logic [W-1:0] lv);
        int idx;
        int n;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (ld) begin
            m_q = lv;
        end else if (e) begin
            idx = index_of(md, m_q);
            n   = md ? 2 * W : W;
            if (idx < 0) begin
                m_q   = 1;
                m_err = 1'b1;
            end else begin
                idx    = d ? (idx + n - 1) % n : (idx + 1) % n;
                m_q    = state_of(md, idx);
                m_wrap = (idx == 0);
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".q"}, 32'(q), 32'(m_q));
        check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
        check({tag, ".err"}, 32'(err), 32'(m_err));
    endtask

    task automatic cycle(input string tag, input logic ld, input logic e,
                         input logic d, input logic md, input logic [W-1:0] lv);
        @(negedge clk);
        load = ld; en = e; dir = d; mode = md; load_val = lv;
        @(posedge clk);
        model_edge(ld, e, d, md, lv);
        #1;
        compare_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        load = 1'b0; en = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_q = 1; m_wrap = 1'b0; m_err = 1'b0;
        compare_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        #12;
        check("reset.q", 32'(q), 32'h1);
        check("reset.wrap", 32'(wrap), 32'h0);
        check("reset.err", 32'(err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Ring up: period 4, wrap on return to 0001.
        for (int i = 0; i < 8; i++) cycle("ring_up", 0, 1, 0, 0, '0);
        check("ring_up_home", 32'(q), 32'h1);
        check("ring_up_wrap", 32'(wrap), 32'h1);

        // Ring down with an enable gap in the middle.
        cycle("ring_dn", 0, 1, 1, 0, '0);
        check("ring_dn_first", 32'(q), 32'h8);
        cycle("ring_dn", 0, 1, 1, 0, '0);
        cycle("ring_hold", 0, 0, 1, 0, '0);
        cycle("ring_hold", 0, 0, 1, 0, '0);
        check("ring_hold_q", 32'(q), 32'h4);
        cycle("ring_dn", 0, 1, 1, 0, '0);
        cycle("ring_dn", 0, 1, 1, 0, '0);
        check("ring_dn_wrap", 32'(wrap), 32'h1);

        // Johnson up from reset: eight states, wrap on 0000.
        async_reset("jrst");
        for (int i = 0; i < 8; i++) begin
            cycle("john_up", 0, 1, 0, 1, '0);
            if (i == 6) check("john_home", 32'(q), 32'h0);
        end
        check("john_up_back", 32'(q), 32'h1);
        cycle("john_ld0", 1, 0, 0, 1, 4'b0000);
        cycle("john_dn", 0, 1, 1, 1, '0);
        check("john_dn_from0", 32'(q), 32'h8);

        // Illegal-state correction in both modes.
        cycle("ill_ld", 1, 0, 0, 0, 4'b0110);
        cycle("ill_fix", 0, 1, 0, 0, '0);
        check("ill_ring_q", 32'(q), 32'h1);
        check("ill_ring_err", 32'(err), 32'h1);
        cycle("ill_next", 0, 1, 0, 0, '0);
        check("ill_next_q", 32'(q), 32'h2);
        cycle("ill_ld", 1, 0, 0, 1, 4'b0101);
        cycle("ill_fix", 0, 1, 0, 1, '0);
        check("ill_john_err", 32'(err), 32'h1);

        // Mode switches leaving an illegal state.
        cycle("msw_ld", 1, 0, 0, 0, 4'b0100);
        cycle("msw_r2j", 0, 1, 0, 1, '0);
        check("msw_r2j_q", 32'(q), 32'h1);
        cycle("msw_ld", 1, 0, 0, 1, 4'b0011);
        cycle("msw_j2r", 0, 1, 0, 0, '0);
        check("msw_j2r_err", 32'(err), 32'h1);

        // Load beats enable, then async reset mid-cycle.
        cycle("ld_en", 1, 1, 0, 0, 4'b1000);
        check("ld_en_q", 32'(q), 32'h8);
        async_reset("arst");

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            logic ld, e, d, md;
            logic [W-1:0] lv;
            if (($urandom % 97) == 0) async_reset("rnd_rst");
            ld = (($urandom % 8) == 0);
            e  = (($urandom % 4) != 0);
            d  = (($urandom % 3) == 0);
            md = (i / 50) % 2 == 1 ? (($urandom % 10) != 0) : (($urandom % 10) == 0);
            lv = W'($urandom);
            cycle("rnd", ld, e, d, md, lv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
